warp_scheduler: RTL
===================

Name: warp_scheduler

Overview:
- Issue stage directly downstream of the instruction buffer/scoreboard.
- Each selection round it picks one warp whose buffered instruction is both valid and hazard-free, using round-robin priority.
- It reserves the instruction's destinations in the scoreboard, then dispatches the packed instruction to the ALU, LSU or branch unit over a valid/ready handshake.

Parameters:
- NUM_WARPS, 32, warp count. Fixed at 32 because warp IDs are 5 bits.
- INSN_W, 63, packed instruction width. Bit fields: rd[62:58], rs1[57:53], rs2[52:48], opcode[47:40], imm[39:8], flags[7:0].

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- warp_valid_mask  in  32  buffer slot holds an instruction
- warp_ready_mask  in  32  scoreboard reports no hazards for that slot
- instruction_buffer  in  63 x 32  packed instruction per warp
- m_tvalid_sb  out  1  one-cycle reservation pulse to the scoreboard
- target_warp  out  5  warp being issued
- target_gpr_out  out  5  {valid, gpr_id[3:0]}
- target_unir_out  out  4  {valid, unir_id[2:0]}
- target_is_pc  out  1  instruction writes PC
- target_is_pred  out  1  instruction writes predicate
- dispatch_warp  out  5  payload: warp ID
- dispatch_insn  out  63  payload: packed instruction
- m_tvalid_alu  out  1  ALU dispatch valid
- m_tready_alu  in  1  ALU ready
- m_tvalid_lsu  out  1  LSU dispatch valid
- m_tready_lsu  in  1  LSU ready
- m_tvalid_bru  out  1  branch-unit dispatch valid
- m_tready_bru  in  1  branch-unit ready
- issue_count  out  32  wrapping count of completed dispatches
- err  out  1  sticky: instruction with no unit flag was selected

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, state=IDLE, rr_ptr=31 so the first search starts at warp 0. Reset mid-dispatch drops the in-flight instruction with no handshake completion.
- Candidate set: cand = warp_valid_mask & warp_ready_mask.
- Winner: the first set bit of cand scanning rr_ptr+1, rr_ptr+2, ... modulo 32.
- IDLE:
  - If cand==0, stay in IDLE.
  - Otherwise latch the winner w and insn = instruction_buffer[w], set rr_ptr=w, go to RESERVE.
- RESERVE (exactly 1 cycle):
  - m_tvalid_sb=1 and target_warp=w.
  - target_gpr_out = {rd<16, rd[3:0]}.
  - target_unir_out = {16<=rd<=23, rd[2:0]}.
  - rd=31 means no destination, so both valid bits are 0.
  - target_is_pc = flags[2]; target_is_pred = flags[4].
  - Unit select, in priority order: flags[1] -> LSU; else flags[2] -> BRU; else flags[0] -> ALU; else set err=1, go to COOLDOWN with no dispatch.
  - After a unit is selected, go to DISPATCH.
- DISPATCH:
  - The selected m_tvalid_* is 1 and dispatch_warp/dispatch_insn are stable.
  - Hold until the matching m_tready_* is 1 at a clk edge; then drop valid the next cycle, issue_count += 1 (wraps at 2^32), go to COOLDOWN.
  - Only one m_tvalid_* is ever high at a time.
- COOLDOWN (1 cycle) -> IDLE. This covers the scoreboard and buffer register latency, so the issued warp's stale ready/valid bits are never re-sampled.
- m_tvalid_sb is high only in RESERVE. All target_* fields are 0 whenever m_tvalid_sb=0.
- Unit-ready levels are ignored outside DISPATCH.
- Throughput: at most 1 issue per 4 cycles with immediate ready (IDLE, RESERVE, DISPATCH, COOLDOWN).
- The payload is sampled in IDLE. Later changes to instruction_buffer do not affect the latched instruction.
- When a wrong-override error occurs, err stays 1 until rst.

Test Plan:
- Reset: hold rst=1, then release -> all outputs 0. Set cand bits 0 and 5 -> warp 0 issues first, then warp 5 (order 0, 5).
- Round-robin: all 32 warps valid and ready, an ALU flags=8'h01 instruction in every slot, m_tready_alu=1 -> target_warp sequence 0..31 then 0. The 33rd issue shows issue_count=33 after it. Issues are spaced 4 cycles apart.
- Destination decode:
  - rd=5 -> target_gpr_out=5'h15, target_unir_out=0.
  - rd=18 -> target_unir_out=4'hA, target_gpr_out=0.
  - rd=31 -> both 0.
  - flags=8'h14 -> is_pc=1, is_pred=1, BRU selected.
- Backpressure: LSU instruction (flags=8'h02) with m_tready_lsu=0 for 10 cycles -> m_tvalid_lsu is held high with a stable payload for the whole stall. cand changes during the stall do not alter the payload. Raising ready -> exactly one transfer.
- Hazard masking: warp 3 valid but ready=0, warp 7 valid and ready -> warp 7 issues. When warp 3 becomes ready, it issues next.
- Error: flags=8'h00 selected -> err=1, one m_tvalid_sb pulse, no m_tvalid_*, issue_count unchanged. err stays high until rst.

Source files
------------

// File: rtl/warp_scheduler.sv
// Issue stage: round-robin pick of a valid, hazard-free warp, scoreboard
// reservation pulse, then valid/ready dispatch to the ALU, LSU or branch unit.
module warp_scheduler #(
  parameter int NUM_WARPS = 32,
  parameter int INSN_W    = 63
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_WARPS-1:0]             warp_valid_mask,
  input  logic [NUM_WARPS-1:0]             warp_ready_mask,
  input  logic [NUM_WARPS-1:0][INSN_W-1:0] instruction_buffer,
  output logic                             m_tvalid_sb,
  output logic [4:0]                       target_warp,
  output logic [4:0]                       target_gpr_out,
  output logic [3:0]                       target_unir_out,
  output logic                             target_is_pc,
  output logic                             target_is_pred,
  output logic [4:0]                       dispatch_warp,
  output logic [INSN_W-1:0]                dispatch_insn,
  output logic                             m_tvalid_alu,
  input  logic                             m_tready_alu,
  output logic                             m_tvalid_lsu,
  input  logic                             m_tready_lsu,
  output logic                             m_tvalid_bru,
  input  logic                             m_tready_bru,
  output logic [31:0]                      issue_count,
  output logic                             err
);

  typedef enum logic [1:0] {IDLE, RESERVE, DISPATCH, COOLDOWN} state_t;

  state_t              state;
  logic [4:0]          rr_ptr;
  logic [NUM_WARPS-1:0] cand;
  logic                win_found;
  logic [4:0]          win_idx;
  logic [4:0]          scan_idx;
  logic [INSN_W-1:0]   sel_insn;
  logic [4:0]          sel_rd;
  logic [4:0]          gpr_next;
  logic [3:0]          unir_next;
  logic                handshake;

  assign cand = warp_valid_mask & warp_ready_mask;

  // Scan starts one past the last winner; the final step wraps back onto rr_ptr itself.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      scan_idx = rr_ptr + 5'(i);
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign sel_insn  = instruction_buffer[win_idx];
  assign sel_rd    = sel_insn[INSN_W-1 -: 5];
  assign gpr_next  = (sel_rd < 5'd16) ? {1'b1, sel_rd[3:0]} : 5'd0;
  assign unir_next = (sel_rd >= 5'd16 && sel_rd <= 5'd23) ? {1'b1, sel_rd[2:0]} : 4'd0;

  assign handshake = (m_tvalid_alu && m_tready_alu) ||
                     (m_tvalid_lsu && m_tready_lsu) ||
                     (m_tvalid_bru && m_tready_bru);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= 5'd31;
      m_tvalid_sb     <= 1'b0;
      target_warp     <= '0;
      target_gpr_out  <= '0;
      target_unir_out <= '0;
      target_is_pc    <= 1'b0;
      target_is_pred  <= 1'b0;
      dispatch_warp   <= '0;
      dispatch_insn   <= '0;
      m_tvalid_alu    <= 1'b0;
      m_tvalid_lsu    <= 1'b0;
      m_tvalid_bru    <= 1'b0;
      issue_count     <= '0;
      err             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            rr_ptr          <= win_idx;
            dispatch_warp   <= win_idx;
            dispatch_insn   <= sel_insn;
            m_tvalid_sb     <= 1'b1;
            target_warp     <= win_idx;
            target_gpr_out  <= gpr_next;
            target_unir_out <= unir_next;
            target_is_pc    <= sel_insn[2];
            target_is_pred  <= sel_insn[4];
            state           <= RESERVE;
          end
        end
        RESERVE: begin
          m_tvalid_sb     <= 1'b0;
          target_warp     <= '0;
          target_gpr_out  <= '0;
          target_unir_out <= '0;
          target_is_pc    <= 1'b0;
          target_is_pred  <= 1'b0;
          // LSU outranks BRU, which outranks ALU; no unit flag is a sticky error.
          if (dispatch_insn[1]) begin
            m_tvalid_lsu <= 1'b1;
            state        <= DISPATCH;
          end else if (dispatch_insn[2]) begin
            m_tvalid_bru <= 1'b1;
            state        <= DISPATCH;
          end else if (dispatch_insn[0]) begin
            m_tvalid_alu <= 1'b1;
            state        <= DISPATCH;
          end else begin
            err   <= 1'b1;
            state <= COOLDOWN;
          end
        end
        DISPATCH: begin
          if (handshake) begin
            m_tvalid_alu <= 1'b0;
            m_tvalid_lsu <= 1'b0;
            m_tvalid_bru <= 1'b0;
            issue_count  <= issue_count + 32'd1;
            state        <= COOLDOWN;
          end
        end
        COOLDOWN: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule
